instr_mem_loader: RTL and testbench

//  Boot-time writer for the instruction memory; the single-cycle CPU core is its only reader.

---
 rtl/instr_mem_loader.sv | 118 +++++++++++
 tb/tb_instr_mem_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time byte-stream writer for the instruction memory.
// Packs big-endian words, writes them in order and holds the core until done.
module instr_mem_loader #(
  parameter int unsigned MEM_BYTES = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic [31:0]      IAddr,
  output logic [31:0]      IDataIn,
  output logic             InsMemRW,
  output logic             mem_sel,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_nxt;
  logic [1:0]       cnt;
  logic [23:0]      word_q;
  logic             take;
  logic             too_long;

  assign take     = byte_valid && byte_ready;
  assign too_long = 32'(load_len) > MAX_WORDS;
  assign idx_nxt  = idx + LEN_W'(1);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      IAddr      <= BASE_ADDR;
      IDataIn    <= 32'h0;
      InsMemRW   <= 1'b1;
      mem_sel    <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      len_q      <= '0;
      idx        <= '0;
      cnt        <= '0;
      word_q     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q    <= load_len;
            idx      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            if (load_len == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (too_long) begin
              state <= DONE;
              err   <= 1'b1;
            end else begin
              state      <= COLLECT;
              byte_ready <= 1'b1;
              mem_sel    <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (take) begin
            word_q <= {word_q[15:0], byte_data};
            cnt    <= cnt + 2'd1;
            // 4th byte completes the word; strobe it next cycle
            if (cnt == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              InsMemRW   <= 1'b0;
              IAddr      <= BASE_ADDR + (32'(idx) << 2);
              IDataIn    <= {word_q, byte_data};
            end
          end
        end
        WRITE: begin
          InsMemRW <= 1'b1;
          idx      <= idx_nxt;
          cnt      <= '0;
          if (idx_nxt == len_q) begin
            state    <= DONE;
            mem_sel  <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state      <= COLLECT;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized bench with a word-level reference model
// of the stream, the memory image and the handshake outputs.
`timescale 1ns/1ps
module tb_instr_mem_loader;
  localparam int MEM_BYTES = 128;
  localparam logic [31:0] BASE = 32'h0;
  localparam int NW = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] load_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic [31:0] IAddr;
  logic [31:0] IDataIn;
  logic        InsMemRW;
  logic        mem_sel;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .MEM_BYTES(MEM_BYTES),
    .BASE_ADDR(BASE),
    .LEN_W(16)
  ) dut (
    .CLK(clk),
    .Reset(Reset),
    .start(start),
    .load_len(load_len),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .IAddr(IAddr),
    .IDataIn(IDataIn),
    .InsMemRW(InsMemRW),
    .mem_sel(mem_sel),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference model: what the loader must show this cycle
  bit          chk_en = 0;
  bit          m_act = 0;
  bit          m_wr = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  bit          m_hold = 1;
  int          m_len = 0;
  int          m_idx = 0;
  int          m_cnt = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_waddr = '0;
  logic [31:0] m_wdata = '0;

  logic [31:0] mem [NW];
  int          n_strobe = 0;
  logic [31:0] last_addr = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byte_ready", 32'(byte_ready), 32'(m_act && !m_wr));
      chk("InsMemRW", 32'(InsMemRW), 32'(!m_wr));
      chk("mem_sel", 32'(mem_sel), 32'(m_act));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      if (m_wr) begin
        chk("IAddr", IAddr, m_waddr);
        chk("IDataIn", IDataIn, m_wdata);
      end
    end
    if (InsMemRW === 1'b0) begin
      n_strobe++;
      last_addr = IAddr;
      if (IAddr >= BASE && IAddr - BASE < 32'(MEM_BYTES))
        mem[int'((IAddr - BASE) >> 2)] = IDataIn;
    end
    if (Reset) begin
      m_act = 0; m_wr = 0; m_done = 0; m_err = 0; m_hold = 1;
      m_cnt = 0; m_idx = 0;
    end else if (m_wr) begin
      m_wr = 0;
      m_idx++;
      m_cnt = 0;
      if (m_idx == m_len) begin
        m_act = 0; m_done = 1; m_hold = 0;
      end
    end else if (m_act) begin
      if (byte_valid) begin
        m_word = {m_word[23:0], byte_data};
        m_cnt++;
        if (m_cnt == 4) begin
          m_wr = 1;
          m_waddr = BASE + 32'(4 * m_idx);
          m_wdata = m_word;
          m_cnt = 0;
        end
      end
    end else if (start) begin
      m_len = int'(load_len);
      m_done = 0; m_err = 0; m_hold = 1; m_idx = 0; m_cnt = 0;
      if (m_len == 0) begin
        m_done = 1; m_hold = 0;
      end else if (m_len * 4 > MEM_BYTES) begin
        m_err = 1;
      end else begin
        m_act = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    load_len = 16'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    bit acc = 0;
    int w = 0;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      if (noise && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        load_len = 16'($urandom);
      end
      tick();
      start = 1'b0;
    end
    byte_valid = 1'b1;
    byte_data = b;
    while (!acc && w < 50) begin
      @(negedge clk);
      acc = byte_ready;
      tick();
      w++;
    end
    byte_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_end();
    bit f = 0;
    for (int w = 0; w < 20 && !f; w++) begin
      @(negedge clk);
      f = done || err;
      if (!f) tick();
    end
    chk("end_timeout", 32'(f), 32'd1);
    tick();
  endtask

  task automatic load_and_check(input int len, input int gap, input bit noise);
    logic [7:0] q[$];
    int s0;
    for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
    s0 = n_strobe;
    do_start(len);
    foreach (q[i])
      send_byte(q[i], gap < 0 ? int'($urandom_range(0, 3)) : gap, noise);
    wait_end();
    chk("strobe_count", 32'(n_strobe - s0), 32'(len));
    for (int w = 0; w < len; w++)
      chk("mem_word", mem[w], {q[4*w], q[4*w+1], q[4*w+2], q[4*w+3]});
  endtask

  initial begin
    logic [7:0] q[$];
    int s0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    Reset = 1'b1;
    tick();
    chk_en = 1;
    tick();
    Reset = 1'b0;

    // idle after reset
    repeat (5) tick();
    @(negedge clk);
    chk("t1_hold", 32'(cpu_hold), 32'd1);
    chk("t1_rw", 32'(InsMemRW), 32'd1);
    chk("t1_sel", 32'(mem_sel), 32'd0);
    chk("t1_ready", 32'(byte_ready), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    tick();

    // two words back-to-back
    q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
    s0 = n_strobe;
    do_start(2);
    foreach (q[i]) send_byte(q[i], 0, 0);
    @(negedge clk);
    chk("t2_strobe", 32'(InsMemRW), 32'd0);
    chk("t2_addr", IAddr, 32'h4);
    chk("t2_data", IDataIn, 32'hAC020008);
    chk("t2_done_early", 32'(done), 32'd0);
    tick();
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd0);
    tick();
    chk("t2_mem0", mem[0], 32'h8C010004);
    chk("t2_mem1", mem[1], 32'hAC020008);
    chk("t2_strobes", 32'(n_strobe - s0), 32'd2);

    // same image with valid gaps
    mem[0] = '0;
    mem[1] = '0;
    s0 = n_strobe;
    do_start(2);
    foreach (q[i]) send_byte(q[i], 2, 0);
    wait_end();
    chk("t3_mem0", mem[0], 32'h8C010004);
    chk("t3_mem1", mem[1], 32'hAC020008);
    chk("t3_strobes", 32'(n_strobe - s0), 32'd2);

    // oversize image, then stray bytes while finished
    s0 = n_strobe;
    do_start(33);
    byte_valid = 1'b1;
    byte_data = 8'h55;
    repeat (3) tick();
    byte_valid = 1'b0;
    @(negedge clk);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    chk("t4_strobes", 32'(n_strobe - s0), 32'd0);
    tick();

    // empty image
    s0 = n_strobe;
    do_start(0);
    @(negedge clk);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_hold", 32'(cpu_hold), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_strobes", 32'(n_strobe - s0), 32'd0);
    tick();

    // reset part-way through a 3-word load
    mem[0] = '0;
    mem[1] = '0;
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    s0 = n_strobe;
    do_start(3);
    foreach (q[i]) send_byte(q[i], 0, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", 32'(byte_ready), 32'd0);
    chk("t6_rw", 32'(InsMemRW), 32'd1);
    chk("t6_sel", 32'(mem_sel), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_addr", IAddr, BASE);
    chk("t6_data", IDataIn, 32'h0);
    tick();
    chk("t6_strobes", 32'(n_strobe - s0), 32'd1);
    chk("t6_mem0", mem[0], 32'h11223344);
    chk("t6_mem1", mem[1], 32'h0);
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_start(1);
    foreach (q[i]) send_byte(q[i], 1, 0);
    wait_end();
    chk("t6_restart_addr", last_addr, BASE);
    chk("t6_restart_mem0", mem[0], 32'hDEADBEEF);

    // full memory, last word at the top address
    load_and_check(NW, -1, 0);
    chk("full_last_addr", last_addr, BASE + 32'(MEM_BYTES - 4));

    // random images with random gaps and ignored start pulses
    for (int r = 0; r < 8; r++)
      load_and_check(int'($urandom_range(1, 8)), -1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
